bcd_countdown_timer: RTL and testbench

//   Parametrised multi-digit BCD down-counter; successor to the single-digit mod-10 countdown.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/bcd_digit_down.sv | 44 ++++
 rtl/bcd_countdown_timer.sv | 88 ++++++++
 tb/tb_bcd_countdown_timer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer datapath: BCD nibble width and
// per-digit modulus rules for plain decimal or MM:SS counting.
package microwave_pkg;

  localparam int BCD_W = 4;

  // Tens-of-seconds (digit 1) and tens-of-hours-style digit 5 count mod 6 in MM:SS mode.
  function automatic int digit_mod(input int i, input bit mmss);
    return (mmss && (i == 1 || i == 5)) ? 6 : 10;
  endfunction

  // Largest representable value, e.g. 16'h9959 for four MM:SS digits.
  function automatic logic [31:0] max_value(input int n, input bit mmss);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) v[k*BCD_W +: BCD_W] = BCD_W'(digit_mod(k, mmss) - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting decade cell with configurable modulus; clamps
// out-of-range load values and wraps 0 -> MOD-1 when stepped.
module bcd_digit_down
  import microwave_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             step,
  output logic [BCD_W-1:0] q,
  output logic             is_zero
);

  localparam logic [BCD_W-1:0] TOP = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] q_reg;
  logic [BCD_W-1:0] q_next;
  logic [BCD_W-1:0] d_clamped;

  always_comb begin
    d_clamped = (d > TOP) ? TOP : d;
    q_next    = q_reg;
    if (load) begin
      q_next = d_clamped;
    end else if (step) begin
      q_next = (q_reg == '0) ? TOP : q_reg - BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q       = q_reg;
  assign is_zero = (q_reg == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown: ripple-borrow chain of decade cells plus
// registered zero flag, one-cycle done pulse and combinational terminal count.
module bcd_countdown_timer
  import microwave_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter bit MMSS_MODE    = 1'b1,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [BCD_W*DIGITS-1:0] data,
  input  logic                    loadn,
  input  logic                    en,
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic                    zero,
  output logic                    tc,
  output logic                    done
);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] step;
  logic all_zero;
  logic one_left;
  logic count_en;
  logic data_zero;
  logic zero_reg, zero_next;
  logic done_reg, done_next;

  assign all_zero  = &is_zero;
  assign one_left  = (digits[BCD_W-1:0] == BCD_W'(1)) && (&is_zero[DIGITS-1:1]);
  assign data_zero = (data == '0);
  // Holding at zero is done by suppressing the borrow chain entirely.
  assign count_en  = en && loadn && !(STOP_AT_ZERO && all_zero);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign step[gi] = count_en;
      end else begin : g_upper
        assign step[gi] = count_en && (&is_zero[gi-1:0]);
      end

      bcd_digit_down #(
        .MOD(digit_mod(gi, MMSS_MODE))
      ) u_digit (
        .clk    (clk),
        .clrn   (clrn),
        .load   (~loadn),
        .d      (data[gi*BCD_W +: BCD_W]),
        .step   (step[gi]),
        .q      (digits[gi*BCD_W +: BCD_W]),
        .is_zero(is_zero[gi])
      );
    end
  endgenerate

  // Clamping preserves zero only for an all-zero load word.
  always_comb begin
    zero_next = zero_reg;
    done_next = 1'b0;
    if (!loadn) begin
      zero_next = data_zero;
    end else if (en) begin
      if (all_zero) begin
        zero_next = STOP_AT_ZERO;
      end else begin
        zero_next = one_left;
        done_next = one_left;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      zero_reg <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      zero_reg <= zero_next;
      done_reg <= done_next;
    end
  end

  assign zero = zero_reg;
  assign done = done_reg;
  assign tc   = en & zero_reg & loadn;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: an MM:SS/hold instance and a decimal/wrap
// instance share stimulus and are compared every cycle to a mixed-radix model.
module tb_bcd_countdown_timer;

  logic        clk   = 1'b0;
  logic        clrn  = 1'b1;
  logic        loadn = 1'b1;
  logic        en    = 1'b0;
  logic [15:0] data  = 16'h0000;

  logic [15:0] dig_a, dig_b;
  logic        zero_a, tc_a, done_a;
  logic        zero_b, tc_b, done_b;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Model state: count value as a plain integer, plus expected done
  int   na   = 0;
  int   nb   = 0;
  logic md_a = 1'b0;
  logic md_b = 1'b0;

  always #5 clk = ~clk;

  bcd_countdown_timer ua (
    .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
    .digits(dig_a), .zero(zero_a), .tc(tc_a), .done(done_a)
  );

  bcd_countdown_timer #(
    .DIGITS(4), .MMSS_MODE(1'b0), .STOP_AT_ZERO(1'b0)
  ) ub (
    .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
    .digits(dig_b), .zero(zero_b), .tc(tc_b), .done(done_b)
  );

  function automatic int modulus(input int i, input bit mmss);
    return (mmss && i == 1) ? 6 : 10;
  endfunction

  function automatic int span(input bit mmss);
    return mmss ? 6000 : 10000;
  endfunction

  function automatic int to_num(input logic [15:0] v, input bit mmss);
    int n, w, nib, m;
    n = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      nib = int'(v[4*i +: 4]);
      m   = modulus(i, mmss);
      if (nib >= m) nib = m - 1;
      n = n + nib * w;
      w = w * m;
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int n, input bit mmss);
    logic [15:0] r;
    int rest, m;
    r    = '0;
    rest = n;
    for (int i = 0; i < 4; i++) begin
      m = modulus(i, mmss);
      r[4*i +: 4] = 4'(rest % m);
      rest = rest / m;
    end
    return r;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: decrement an integer in mixed radix
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      na <= 0; nb <= 0; md_a <= 1'b0; md_b <= 1'b0;
    end else if (!loadn) begin
      na <= to_num(data, 1'b1); nb <= to_num(data, 1'b0);
      md_a <= 1'b0; md_b <= 1'b0;
    end else if (en) begin
      na   <= (na == 0) ? 0 : na - 1;
      md_a <= (na == 1);
      nb   <= (nb == 0) ? span(1'b0) - 1 : nb - 1;
      md_b <= (nb == 1);
    end else begin
      md_a <= 1'b0; md_b <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk16("a.digits", dig_a, to_bcd(na, 1'b1));
    chk1 ("a.zero",   zero_a, na == 0);
    chk1 ("a.done",   done_a, md_a);
    chk1 ("a.tc",     tc_a, en && loadn && (na == 0));
    chk16("b.digits", dig_b, to_bcd(nb, 1'b0));
    chk1 ("b.zero",   zero_b, nb == 0);
    chk1 ("b.done",   done_b, md_b);
    chk1 ("b.tc",     tc_b, en && loadn && (nb == 0));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    $display("txn t=%0t loadn=%b en=%b data=%h -> a=%h z=%b d=%b | b=%h z=%b d=%b",
             $time, loadn, en, data, dig_a, zero_a, done_a, dig_b, zero_b, done_b);
  endtask

  initial begin
    // Reset
    #1 clrn = 1'b0;
    #2;
    chk16("rst.digits", dig_a, 16'h0000);
    chk1 ("rst.zero",   zero_a, 1'b1);
    chk1 ("rst.done",   done_a, 1'b0);
    chk16("rst.b",      dig_b, 16'h0000);
    #2 clrn = 1'b1;
    #2 en = 1'b1;
    #1;
    chk1("rst.tc_a", tc_a, 1'b1);
    chk1("rst.tc_b", tc_b, 1'b1);
    cycle();
    chk16("hold.a", dig_a, 16'h0000);
    chk1 ("hold.tc_a", tc_a, 1'b1);
    chk16("wrap.b", dig_b, 16'h9999);

    // MM:SS tens wrap
    data = 16'h0100; loadn = 1'b0;
    cycle();
    chk16("mmss.load", dig_a, 16'h0100);
    loadn = 1'b1;
    cycle();
    chk16("mmss.step1", dig_a, 16'h0059);
    chk16("dec.step1",  dig_b, 16'h0099);
    cycle();
    chk16("mmss.step2", dig_a, 16'h0058);

    // Count to zero, done pulse, then hold
    data = 16'h0002; loadn = 1'b0;
    cycle();
    chk16("z.load", dig_a, 16'h0002);
    chk1 ("z.load_done", done_a, 1'b0);
    loadn = 1'b1;
    cycle();
    chk16("z.one", dig_a, 16'h0001);
    cycle();
    chk16("z.zero", dig_a, 16'h0000);
    chk1 ("z.zero_flag", zero_a, 1'b1);
    chk1 ("z.done_a", done_a, 1'b1);
    chk1 ("z.done_b", done_b, 1'b1);
    cycle();
    chk16("z.held", dig_a, 16'h0000);
    chk1 ("z.done_drop", done_a, 1'b0);
    chk1 ("z.tc", tc_a, 1'b1);
    chk16("z.wrap_b", dig_b, 16'h9999);

    // Clamp of illegal nibbles, load of zero, hold with en=0
    en = 1'b0; data = 16'hFC7A; loadn = 1'b0;
    cycle();
    chk16("clamp.a", dig_a, 16'h9959);
    chk16("clamp.b", dig_b, 16'h9979);
    chk1 ("clamp.done", done_a, 1'b0);
    data = 16'h0000;
    cycle();
    chk16("load0.a", dig_a, 16'h0000);
    chk1 ("load0.zero", zero_a, 1'b1);
    chk1 ("load0.done", done_a, 1'b0);
    loadn = 1'b1;
    cycle();
    chk1("hold0.done", done_a, 1'b0);

    // Load beats enable; async reset mid-count
    en = 1'b1; data = 16'h0030; loadn = 1'b0;
    cycle();
    chk16("prio.load", dig_a, 16'h0030);
    loadn = 1'b1;
    cycle();
    chk16("prio.step1", dig_a, 16'h0029);
    cycle();
    chk16("prio.step2", dig_a, 16'h0028);
    #2 clrn = 1'b0;
    #1;
    chk16("arst.a", dig_a, 16'h0000);
    chk1 ("arst.zero", zero_a, 1'b1);
    chk16("arst.b", dig_b, 16'h0000);
    clrn = 1'b1;

    // 1:05 runs down to zero within 70 cycles with exactly one done
    data = 16'h0105; loadn = 1'b0;
    cycle();
    loadn = 1'b1;
    pulses = 0;
    repeat (70) begin
      cycle();
      if (done_a) pulses++;
    end
    chk16("run.pulses", 16'(pulses), 16'd1);
    chk16("run.end", dig_a, 16'h0000);

    // Assorted loads (including illegal nibbles), model-checked
    for (int k = 0; k < 6; k++) begin
      data = 16'($urandom); loadn = 1'b0;
      cycle();
      loadn = 1'b1;
      repeat (3) cycle();
    end

    en = 1'b0;
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
